// File: rtl/imem_boot_loader.sv
// Boot-loading instruction memory: clears to NOP, takes a little-endian byte stream, then serves fetches.
// Optional running word checksum output enabled by defining IMEM_CHECKSUM_EN.
module imem_boot_loader #(
    parameter int          DEPTH  = 256,
    parameter int          ADDR_W = $clog2(DEPTH),
    parameter logic [31:0] NOP    = 32'h00000013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [7:0]        ld_byte,
    input  logic              ld_last,
    input  logic [31:0]       pcF,
    output logic [31:0]       instrF,
    output logic              core_rst_n,
    output logic              load_done,
    output logic [ADDR_W:0]   word_count,
    output logic              overflow
`ifdef IMEM_CHECKSUM_EN
    ,
    output logic [31:0]       checksum
`endif
);
    typedef enum logic [1:0] {CLEAR, LOAD, RUN} state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   clr_idx_q;
    logic [1:0]          lane_q;
    logic [31:0]         asm_q;
    logic [ADDR_W:0]     wcnt_q;
    logic                ready_q, done_q, crst_n_q, ovf_q;
    logic [31:0]         mem [DEPTH];

    logic                xfer, word_end, full;
    logic [31:0]         asm_word;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_wa;
    logic [31:0]         mem_wd;

    assign xfer     = ld_valid & ready_q;
    assign word_end = xfer & ((lane_q == 2'd3) | ld_last);
    assign full     = (wcnt_q == (ADDR_W+1)'(DEPTH));
    // asm_q is cleared after each write, so unfilled upper lanes are zero
    assign asm_word = asm_q | ({24'b0, ld_byte} << {lane_q, 3'b000});

    always_comb begin
        mem_we = 1'b0;
        mem_wa = clr_idx_q;
        mem_wd = NOP;
        if (state_q == CLEAR) begin
            mem_we = 1'b1;
        end else if (word_end && !full) begin
            mem_we = 1'b1;
            mem_wa = wcnt_q[ADDR_W-1:0];
            mem_wd = asm_word;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
    end

`ifdef IMEM_CHECKSUM_EN
    logic [31:0] csum_q;
    assign checksum = csum_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
            lane_q    <= '0;
            asm_q     <= '0;
            wcnt_q    <= '0;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
            crst_n_q  <= 1'b0;
            ovf_q     <= 1'b0;
`ifdef IMEM_CHECKSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            case (state_q)
                CLEAR: begin
                    clr_idx_q <= clr_idx_q + 1'b1;
                    if (clr_idx_q == ADDR_W'(DEPTH-1)) begin
                        state_q <= LOAD;
                        ready_q <= 1'b1;
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        if (full) ovf_q <= 1'b1;
                        if (word_end) begin
                            lane_q <= '0;
                            asm_q  <= '0;
                            if (!full) begin
                                wcnt_q <= wcnt_q + 1'b1;
`ifdef IMEM_CHECKSUM_EN
                                csum_q <= csum_q + asm_word;
`endif
                            end
                        end else begin
                            lane_q <= lane_q + 1'b1;
                            asm_q  <= asm_word;
                        end
                        if (ld_last) begin
                            state_q <= RUN;
                            ready_q <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // one-cycle delayed release so the core sees a clean edge
                    crst_n_q <= 1'b1;
                end
                default: state_q <= CLEAR;
            endcase
        end
    end

    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^pcF[1:0];

    always_comb begin
        instrF = NOP;
        if (state_q == RUN && pcF[31:ADDR_W+2] == '0)
            instrF = mem[pcF[ADDR_W+1:2]];
    end

    assign ld_ready   = ready_q;
    assign load_done  = done_q;
    assign core_rst_n = crst_n_q;
    assign word_count = wcnt_q;
    assign overflow   = ovf_q;
endmodule
